rad_async_fifo_wctrl: RTL and testbench

- Write-side front end of the async FIFO, in the wclk domain, directly upstream of the write-pointer/full stage.
- Accepts a valid/ready stream and holds words in a 2-entry buffer so s_ready is registered.
- Drives winc/wdata into the write pointer and memory, honouring wfull.
- Computes a registered fill level and almost-full flag from the local Gray write pointer and the synchronized Gray read pointer.

---
 rtl/rad_async_fifo_pkg.sv | 23 ++
 rtl/rad_async_fifo_skid.sv | 67 ++++++
 rtl/rad_async_fifo_wctrl.sv | 80 ++++++++
 tb/tb_rad_async_fifo_wctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rad_async_fifo_pkg.sv
// Shared types and Gray-code helpers for the async FIFO write/read control blocks.
package rad_async_fifo_pkg;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} wbuf_state_t;

  // Widest pointer the helpers handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W = 32;

  // Zero-extension is harmless: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rad_async_fifo_skid.sv
// Two-entry in-order buffer (head H, skid K) giving a registered in_ready on the write side.
module rad_async_fifo_skid
  import rad_async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_pop,
  output logic [DSIZE-1:0] out_data
);

  wbuf_state_t      state;
  logic [DSIZE-1:0] h_data;
  logic [DSIZE-1:0] k_data;
  logic             accept;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = h_data;

  // in_ready is written alongside state so it always equals (state != FULL) after the edge.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      h_data   <= '0;
      k_data   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            h_data <= in_data;
            state  <= HALF;
          end
        end
        HALF: begin
          if (accept && out_pop) begin
            h_data <= in_data;
          end else if (accept) begin
            k_data   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_pop) begin
            h_data   <= k_data;
            state    <= HALF;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/rad_async_fifo_wctrl.sv
// Async FIFO write-side front end: skid buffer, registered fill level / almost-full, optional stats.
// Define RAD_ASYNC_FIFO_WCTRL_STATS_EN to build the stall/word counters; otherwise they read 0.
module rad_async_fifo_wctrl
  import rad_async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ADDRSIZE  = 3,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  output logic                s_ready,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         word_cnt
);

  localparam logic [ADDRSIZE:0] AF_T = (ADDRSIZE + 1)'(AF_THRESH);

  logic              h_valid;
  logic [ADDRSIZE:0] lvl_d;

  assign winc = h_valid && !wfull;

  rad_async_fifo_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .wclk      (wclk),
    .wrst      (wrst),
    .in_valid  (s_valid),
    .in_data   (s_data),
    .in_ready  (s_ready),
    .out_valid (h_valid),
    .out_pop   (winc),
    .out_data  (wdata)
  );

  // Truncating the difference gives the modulo-2**(ADDRSIZE+1) wrap for free.
  assign lvl_d = (ADDRSIZE + 1)'(gray2bin(PTR_MAX_W'(wptr_gray)) - gray2bin(PTR_MAX_W'(wq2_rptr)));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= lvl_d;
      walmost_full <= (lvl_d >= AF_T);
    end
  end

`ifdef RAD_ASYNC_FIFO_WCTRL_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] word_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      stall_q <= '0;
      word_q  <= '0;
    end else begin
      if (s_valid && !s_ready && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (winc && (word_q != '1))                 word_q  <= word_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign word_cnt  = word_q;
`else
  assign stall_cnt = '0;
  assign word_cnt  = '0;
`endif

endmodule

// File: tb/tb_rad_async_fifo_wctrl.sv
// Bench for rad_async_fifo_wctrl: directed scenarios plus random traffic against a queue-based model.
module tb_rad_async_fifo_wctrl;

  logic        wclk = 1'b0;
  logic        wrst, s_valid, s_ready, winc, wfull, walmost_full;
  logic [7:0]  s_data, wdata;
  logic [3:0]  wptr_gray, wq2_rptr, wlevel;
  logic [15:0] stall_cnt, word_cnt;

  rad_async_fifo_wctrl #(
    .DSIZE     (8),
    .ADDRSIZE  (3),
    .AF_THRESH (6)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .wptr_gray    (wptr_gray),
    .wq2_rptr     (wq2_rptr),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .stall_cnt    (stall_cnt),
    .word_cnt     (word_cnt)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  byte unsigned q[$];
  bit  m_valid = 1'b0;
  bit  m_ready;
  bit  m_af;
  int  m_lvl, m_stall, m_word;
  int  pw = 0, pr = 0;
  bit  adv = 1'b0;
  int  nwrites = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] g_of(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic int b_of(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (g_of(b) == g) return b;
    return 0;
  endfunction

  // One clock: drive, check just before the edge, update model at the edge, return at negedge.
  task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit f);
    bit pop, acc;
    int wb, rb;
    wb = pw & 15;
    rb = pr & 15;
    wrst = rst; s_valid = v; s_data = d; wfull = f;
    wptr_gray = g_of(wb); wq2_rptr = g_of(rb);
    #1;
    pop = (q.size() > 0) && !f;
    if (m_valid) begin
      check("s_ready", s_ready, m_ready);
      check("winc", winc, pop);
      if (q.size() > 0) check("wdata", wdata, q[0]);
      check("wlevel", wlevel, m_lvl);
      check("walmost_full", walmost_full, m_af);
      check("stall_cnt", stall_cnt, m_stall);
      check("word_cnt", word_cnt, m_word);
    end
    @(posedge wclk);
    if (rst) begin
      q.delete();
      m_ready = 1'b1; m_lvl = 0; m_af = 1'b0; m_stall = 0; m_word = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      acc = v && m_ready;
`ifdef RAD_ASYNC_FIFO_WCTRL_STATS_EN
      if (v && !m_ready && m_stall < 65535) m_stall++;
      if (pop && m_word < 65535) m_word++;
`endif
      if (pop) begin
        void'(q.pop_front());
        nwrites++;
        if (adv) pw = (pw + 1) & 15;
      end
      if (acc) q.push_back(d);
      m_ready = (q.size() < 2);
      m_lvl   = (wb - rb) & 15;
      m_af    = (m_lvl >= 6);
    end
    @(negedge wclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int idx, c;
    bit rdy;
    wrst = 1'b1; s_valid = 1'b0; s_data = '0; wfull = 1'b0;
    wptr_gray = '0; wq2_rptr = '0;
    @(negedge wclk);

    // Reset and idle
    cycle(1, 0, 8'h00, 0);
    check("rst_wdata", wdata, 8'h00);
    repeat (3) cycle(0, 0, 8'h00, 0);
    check("idle_ready", s_ready, 1);

    // Stream 0x10..0x17 with the write pointer advancing on winc
    adv = 1'b1; nwrites = 0;
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'h10 + i), 0);
    repeat (3) cycle(0, 0, 8'h00, 0);
    check("stream_writes", nwrites, 8);
    adv = 1'b0;

    // Backpressure: wfull held for 4 cycles while offering 0xA0..0xA3
    idx = 0; c = 0; nwrites = 0;
    while (idx < 4 && c < 40) begin
      rdy = m_ready;
      if (c == 2) check("bp_ready_low", s_ready, 0);
      cycle(0, 1, 8'(8'hA0 + idx), (c < 4));
      if (rdy) idx++;
      c++;
    end
    repeat (4) cycle(0, 0, 8'h00, 0);
    check("bp_writes", nwrites, 4);
    check("bp_ready_back", s_ready, 1);

    // Level and almost-full
    pw = 6; pr = 0;
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("lvl6", wlevel, 6);
    check("af6", walmost_full, 1);
    pr = 1;
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("lvl5", wlevel, 5);
    check("af5", walmost_full, 0);

    // Wrap-around cases
    pw = 2; pr = 10;
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("wrap_full", wlevel, 8);
    pw = 1; pr = 15;
    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    check("wrap_2", wlevel, 2);
    pw = 0; pr = 0;

    // Reset while two words are buffered
    cycle(0, 1, 8'h55, 1);
    cycle(0, 1, 8'h66, 1);
    check("full_ready_low", s_ready, 0);
    cycle(1, 1, 8'h77, 1);
    check("rst_ready", s_ready, 1);
    check("rst_winc", winc, 0);
    cycle(0, 0, 8'h00, 0);

    // Stall counting: fill, then 300 stalled cycles
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h01, 1);
    cycle(0, 1, 8'h02, 1);
    repeat (300) cycle(0, 1, 8'h03, 1);
    cycle(0, 0, 8'h00, 1);
`ifdef RAD_ASYNC_FIFO_WCTRL_STATS_EN
    check("stall_300", stall_cnt, 300);
    force dut.stall_q = 16'hFFFE;
    #1 release dut.stall_q;
    m_stall = 65534;
    repeat (4) cycle(0, 1, 8'h03, 1);
    check("stall_sat", stall_cnt, 16'hFFFF);
`else
    check("stall_off", stall_cnt, 0);
`endif

    // Random traffic
    cycle(1, 0, 8'h00, 0);
    pw = 0; pr = 0; adv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ((pr != pw) && ($urandom_range(0, 2) == 0)) pr = (pr + 1) & 15;
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
